// File: rtl/led_matrix_pkg.sv
// Shared constants, FSM state type and row extraction for the 6x6 LED matrix scanner.
package led_matrix_pkg;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 6;
  localparam int unsigned IMG_W = 36;

  typedef enum logic {ST_BLANK, ST_ON} state_e;

  function automatic logic [COLS-1:0] row_slice(input logic [IMG_W-1:0] img,
                                                input logic [2:0]       r);
    return img[COLS*r +: COLS];
  endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// Loadable down-counter with a terminal-count flag; holds at zero rather than wrapping.
module scan_timer #(
  parameter int unsigned    CW      = 4,
  parameter logic [CW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 6x6 LED matrix driver with double-buffered image, blanking and PWM brightness.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 2000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          ROW_ACTIVE_LOW = 1'b1,
  parameter bit          COL_ACTIVE_LOW = 1'b0,
  parameter int unsigned PWM_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IMG_W-1:0]    img_in,
  input  logic                img_valid,
  output logic                img_ready,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [ROWS-1:0]     row_drv,
  output logic [COLS-1:0]     col_drv,
  output logic                frame_done
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned DW      = (CW > PWM_BITS) ? CW : PWM_BITS;

  localparam logic [ROWS-1:0] ROW_OFF = ROW_ACTIVE_LOW ? '1 : '0;
  localparam logic [COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? '1 : '0;

  state_e              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [PWM_BITS-1:0] bri_q, bri_d;
  logic [IMG_W-1:0]    active_q, active_d;
  logic [IMG_W-1:0]    shadow_q, shadow_d;
  logic                ready_q, ready_d;
  logic [ROWS-1:0]     row_drv_q, row_drv_d;
  logic [COLS-1:0]     col_drv_q, col_drv_d;
  logic                frame_done_q, frame_done_d;

  logic [CW-1:0]       cnt;
  logic                tc;
  logic [CW-1:0]       load_val;
  logic [PWM_BITS-1:0] phase;
  logic                lit;
  logic [ROWS-1:0]     sel;
  logic [COLS-1:0]     cols;

  // The timer counts down, so the dwell index is recovered as (DWELL-1) - cnt.
  assign load_val = (state_q == ST_BLANK) ? CW'(DWELL_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
  assign phase    = PWM_BITS'(DW'(DWELL_CYCLES - 1) - DW'(cnt));
  assign lit      = (phase < bri_q) || (bri_q == '1);

  scan_timer #(
    .CW      (CW),
    .RST_VAL (CW'(BLANK_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tc),
    .load_val (load_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bri_d        = bri_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    sel          = '0;
    cols         = '0;

    if (img_valid && ready_q) begin
      shadow_d = img_in;
      ready_d  = 1'b0;
    end

    unique case (state_q)
      ST_BLANK: begin
        if (tc) begin
          bri_d   = brightness;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        sel = ROWS'(1) << row_q;
        if (lit) cols = row_slice(active_q, row_q);
        if (tc) begin
          state_d = ST_BLANK;
          row_d   = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;
          if (row_q == 3'd5) begin
            frame_done_d = 1'b1;
            // Shadow is full exactly when ready is low, so no accept can collide here.
            if (!ready_q) begin
              active_d = shadow_q;
              ready_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase

    row_drv_d = ROW_ACTIVE_LOW ? ~sel : sel;
    col_drv_d = COL_ACTIVE_LOW ? ~cols : cols;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      row_q        <= '0;
      bri_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      ready_q      <= 1'b1;
      row_drv_q    <= ROW_OFF;
      col_drv_q    <= COL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bri_q        <= bri_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      ready_q      <= ready_d;
      row_drv_q    <= row_drv_d;
      col_drv_q    <= col_drv_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign img_ready  = ready_q;
  assign row_drv    = row_drv_q;
  assign col_drv    = col_drv_q;
  assign frame_done = frame_done_q;

endmodule
